// File: rtl/glitcbus_master.sv
// glitcbus_master
//   Converts single 32-bit register read/write requests into byte-serial
//   GLITCBUS transactions. Bus timing is paced by ce_i, the half-rate enable
//   from the GLITCBUS clock generator, so each FSM state lasts one bus cycle.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   ce_i                bus-cycle enable (one clk_i wide)
//   req_i, wr_i         request strobe and direction (1=write)
//   glitc_i, addr_i     target GLITC index and register address
//   wdata_i             write data
//   busy_o, ack_o       transaction pending/in progress, completion pulse
//   rdata_o             read data, valid with ack_o, held until the next read
//   gsel_b_o            active-low per-GLITC selects
//   grdwr_b_o           1=read, 0=write
//   gad_o, gad_oe_o     address/data byte out and its output enable
//   gad_i               address/data byte in (registered at the pad)
module glitcbus_master #(
  parameter int NUM_GLITC      = 4,
  parameter int TIMEOUT_UNUSED = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic                 req_i,
  input  logic                 wr_i,
  input  logic [1:0]           glitc_i,
  input  logic [7:0]           addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 busy_o,
  output logic                 ack_o,
  output logic [31:0]          rdata_o,
  output logic [NUM_GLITC-1:0] gsel_b_o,
  output logic                 grdwr_b_o,
  output logic [7:0]           gad_o,
  output logic                 gad_oe_o,
  input  logic [7:0]           gad_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WD0, S_WD1, S_WD2, S_WD3,
    S_TURN, S_RD0, S_RD1, S_RD2, S_RD3, S_GAP
  } state_t;

  state_t state_reg, state_next;

  logic                 pending_reg, busy_reg, ack_reg;
  logic                 wr_reg;
  logic [1:0]           glitc_reg;
  logic [7:0]           addr_reg;
  logic [31:0]          wdata_reg;
  logic [23:0]          rbuf_reg;
  logic [31:0]          rdata_reg;
  logic [NUM_GLITC-1:0] gsel_b_reg, gsel_b_next, sel_b;
  logic                 grdwr_b_reg, grdwr_b_next;
  logic [7:0]           gad_reg, gad_next;
  logic                 oe_reg, oe_next;
  logic                 accept, in_range;

  // No timeout logic exists; the parameter is kept only for interface
  // compatibility and is expected to stay 0.
  if (TIMEOUT_UNUSED != 0) begin : g_timeout_reserved
  end

  assign accept   = req_i && !busy_reg;
  assign in_range = int'(glitc_reg) < NUM_GLITC;

  // Select pattern for the latched target; an out-of-range index matches no
  // bit, so the transaction runs with every select left high.
  for (genvar gi = 0; gi < NUM_GLITC; gi++) begin : g_sel
    assign sel_b[gi] = (glitc_reg != 2'(gi));
  end

  // Request capture. busy covers the wait for the bus plus the whole
  // transaction including GAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= 1'b0;
      busy_reg    <= 1'b0;
      wr_reg      <= 1'b0;
      glitc_reg   <= 2'd0;
      addr_reg    <= 8'd0;
      wdata_reg   <= 32'd0;
    end else begin
      if (accept) begin
        pending_reg <= 1'b1;
        busy_reg    <= 1'b1;
        wr_reg      <= wr_i;
        glitc_reg   <= glitc_i;
        addr_reg    <= addr_i;
        wdata_reg   <= wdata_i;
      end
      if (ce_i && state_reg == S_IDLE && pending_reg) pending_reg <= 1'b0;
      if (ce_i && state_reg == S_GAP) busy_reg <= 1'b0;
    end
  end

  // Next state, and the bus outputs belonging to the state being entered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (pending_reg) state_next = S_ADDR;
      S_ADDR:  state_next = wr_reg ? S_WD0 : S_TURN;
      S_WD0:   state_next = S_WD1;
      S_WD1:   state_next = S_WD2;
      S_WD2:   state_next = S_WD3;
      S_WD3:   state_next = S_GAP;
      S_TURN:  state_next = S_RD0;
      S_RD0:   state_next = S_RD1;
      S_RD1:   state_next = S_RD2;
      S_RD2:   state_next = S_RD3;
      S_RD3:   state_next = S_GAP;
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    gsel_b_next  = '1;
    grdwr_b_next = 1'b1;
    gad_next     = gad_reg;   // GAD keeps its last value while not driven
    oe_next      = 1'b0;
    case (state_next)
      S_ADDR: begin
        gsel_b_next  = sel_b;
        grdwr_b_next = ~wr_reg;
        gad_next     = addr_reg;
        oe_next      = 1'b1;
      end
      S_WD0, S_WD1, S_WD2, S_WD3: begin
        gsel_b_next  = sel_b;
        grdwr_b_next = ~wr_reg;
        oe_next      = 1'b1;
        case (state_next)
          S_WD0:   gad_next = wdata_reg[7:0];
          S_WD1:   gad_next = wdata_reg[15:8];
          S_WD2:   gad_next = wdata_reg[23:16];
          default: gad_next = wdata_reg[31:24];
        endcase
      end
      S_TURN, S_RD0, S_RD1, S_RD2, S_RD3: begin
        gsel_b_next  = sel_b;
        grdwr_b_next = ~wr_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= S_IDLE;
      gsel_b_reg  <= '1;
      grdwr_b_reg <= 1'b1;
      gad_reg     <= 8'd0;
      oe_reg      <= 1'b0;
      ack_reg     <= 1'b0;
      rbuf_reg    <= 24'd0;
      rdata_reg   <= 32'd0;
    end else begin
      ack_reg <= 1'b0;
      if (ce_i) begin
        state_reg   <= state_next;
        gsel_b_reg  <= gsel_b_next;
        grdwr_b_reg <= grdwr_b_next;
        gad_reg     <= gad_next;
        oe_reg      <= oe_next;
        // Each read byte is sampled on the edge that ends its beat.
        case (state_reg)
          S_RD0: rbuf_reg[7:0]   <= gad_i;
          S_RD1: rbuf_reg[15:8]  <= gad_i;
          S_RD2: rbuf_reg[23:16] <= gad_i;
          S_RD3: begin
            ack_reg   <= 1'b1;
            rdata_reg <= in_range ? {gad_i, rbuf_reg} : 32'hFFFF_FFFF;
          end
          S_WD3: ack_reg <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign busy_o    = busy_reg;
  assign ack_o     = ack_reg;
  assign rdata_o   = rdata_reg;
  assign gsel_b_o  = gsel_b_reg;
  assign grdwr_b_o = grdwr_b_reg;
  assign gad_o     = gad_reg;
  assign gad_oe_o  = oe_reg;

endmodule

// File: tb/tb_glitcbus_master.sv
// tb_glitcbus_master
//   Drives two glitcbus_master instances (NUM_GLITC=4 and NUM_GLITC=2) from
//   the same stimulus and compares every output, every clock, against an
//   expected bus-beat sequence derived from the transaction description.
module tb_glitcbus_master;

  logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, req = 1'b0, wr = 1'b0;
  logic [1:0]  glitc = 2'd0;
  logic [7:0]  addr = 8'd0, gad_in = 8'd0;
  logic [31:0] wdata = 32'd0;

  logic        busy4, ack4, rdwr4, oe4, busy2, ack2, rdwr2, oe2;
  logic [31:0] rdata4, rdata2;
  logic [3:0]  gsel4;
  logic [1:0]  gsel2;
  logic [7:0]  gad4, gad2;

  int errors = 0;
  int checks = 0;

  // Expected current output values.
  logic [3:0]  cur_sel4 = 4'hF;
  logic [1:0]  cur_sel2 = 2'b11;
  logic        cur_rdwr = 1'b1, cur_oe = 1'b0, cur_busy = 1'b0, exp_ack = 1'b0;
  logic [7:0]  cur_gad = 8'd0;
  logic [31:0] rd4_exp = 32'd0, rd2_exp = 32'd0;

  // Fields of a request queued to be raised in the ack cycle.
  logic        nx_wr;
  logic [1:0]  nx_glitc;
  logic [7:0]  nx_addr;
  logic [31:0] nx_wdata;

  typedef struct packed {
    logic        wr;
    logic [1:0]  glitc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] slave;
    logic [3:0]  sel4;
    logic [1:0]  sel2;
    logic [31:0] rd4;
    logic [31:0] rd2;
  } vec_t;
  vec_t vecs [6];

  glitcbus_master #(.NUM_GLITC(4), .TIMEOUT_UNUSED(0)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .wr_i(wr),
    .glitc_i(glitc), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy4), .ack_o(ack4), .rdata_o(rdata4), .gsel_b_o(gsel4),
    .grdwr_b_o(rdwr4), .gad_o(gad4), .gad_oe_o(oe4), .gad_i(gad_in)
  );

  glitcbus_master #(.NUM_GLITC(2), .TIMEOUT_UNUSED(0)) dut_n2 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .wr_i(wr),
    .glitc_i(glitc), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy2), .ack_o(ack2), .rdata_o(rdata2), .gsel_b_o(gsel2),
    .grdwr_b_o(rdwr2), .gad_o(gad2), .gad_oe_o(oe2), .gad_i(gad_in)
  );

  always #5 clk = ~clk;

  // Half-rate enable, one clk wide, changing away from the rising edge.
  initial forever begin
    @(negedge clk);
    ce = ~ce;
  end

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h, expected %h", tag, name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "gsel4", 32'(gsel4), 32'(cur_sel4));
    chk(tag, "gsel2", 32'(gsel2), 32'(cur_sel2));
    chk(tag, "rdwr4", 32'(rdwr4), 32'(cur_rdwr));
    chk(tag, "rdwr2", 32'(rdwr2), 32'(cur_rdwr));
    chk(tag, "oe4",   32'(oe4),   32'(cur_oe));
    chk(tag, "oe2",   32'(oe2),   32'(cur_oe));
    chk(tag, "gad4",  32'(gad4),  32'(cur_gad));
    chk(tag, "gad2",  32'(gad2),  32'(cur_gad));
    chk(tag, "busy4", 32'(busy4), 32'(cur_busy));
    chk(tag, "busy2", 32'(busy2), 32'(cur_busy));
    chk(tag, "ack4",  32'(ack4),  32'(exp_ack));
    chk(tag, "ack2",  32'(ack2),  32'(exp_ack));
    chk(tag, "rdata4", rdata4, rd4_exp);
    chk(tag, "rdata2", rdata2, rd2_exp);
  endtask

  // One clock; outputs are sampled 1ns after the edge. ce_edge reports
  // whether that edge was a bus-cycle edge.
  task automatic step(output bit ce_edge);
    @(posedge clk);
    ce_edge = ce;
    #1;
  endtask

  // Steps to the next ce edge, checking the non-ce samples on the way.
  task automatic advance(input string tag);
    bit cee;
    int n;
    n = 0;
    exp_ack = 1'b0;
    step(cee);
    while (!cee && n < 8) begin
      check_all(tag);
      step(cee);
      n++;
    end
    if (!cee) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ce edge seen, required one within 8 clocks", tag);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    bit cee;
    exp_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(cee);
      check_all(tag);
    end
  endtask

  // mode 0: one-clock request; mode 1: request held with junk fields while
  // busy; mode 2: next request (nx_*) raised in the ack cycle.
  // abort_at >= 0 applies reset during that beat and ends the transaction.
  task automatic run_txn(input logic w, input logic [1:0] g, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] sl,
                         input logic [3:0] s4, input logic [1:0] s2,
                         input logic [31:0] e4, input logic [31:0] e2,
                         input int mode, input int abort_at, input string tag);
    bit cee;
    int last;
    last = w ? 5 : 6;
    chk(tag, "idle_before_req", 32'(busy4), 32'd0);
    req = 1'b1; wr = w; glitc = g; addr = a; wdata = d;
    step(cee);
    cur_busy = 1'b1;
    exp_ack  = 1'b0;
    req   = (mode == 1);
    wr    = 1'($urandom);
    glitc = 2'($urandom);
    addr  = 8'($urandom);
    wdata = $urandom;
    check_all({tag, "/accept"});

    for (int b = 0; b <= last; b++) begin
      advance(tag);
      if (b == 0) begin
        cur_sel4 = s4; cur_sel2 = s2; cur_rdwr = ~w; cur_oe = 1'b1; cur_gad = a;
      end else if (b == last) begin
        cur_sel4 = 4'hF; cur_sel2 = 2'b11; cur_rdwr = 1'b1; cur_oe = 1'b0;
        exp_ack = 1'b1; rd4_exp = e4; rd2_exp = e2;
      end else if (w) begin
        cur_oe = 1'b1; cur_gad = d[8*(b-1) +: 8];
      end else begin
        cur_oe = 1'b0;
      end
      check_all($sformatf("%s/beat%0d", tag, b));

      if (b == abort_at) begin
        rst = 1'b1; req = 1'b0;
        step(cee);
        cur_sel4 = 4'hF; cur_sel2 = 2'b11; cur_rdwr = 1'b1; cur_oe = 1'b0;
        cur_gad = 8'd0; cur_busy = 1'b0; exp_ack = 1'b0;
        rd4_exp = 32'd0; rd2_exp = 32'd0;
        check_all({tag, "/reset"});
        rst = 1'b0;
        idle_cycles(8, {tag, "/after_reset"});
        $display("txn %s wr=%0d glitc=%0d addr=%h aborted by reset at beat %0d",
                 tag, w, g, a, b);
        return;
      end

      // The addressed GLITC presents byte n during RDn; junk otherwise.
      if (!w && b >= 2 && b <= 5) gad_in = sl[8*(b-2) +: 8];
      else gad_in = 8'($urandom);

      if (b == last) begin
        if (mode == 1) req = 1'b0;
        if (mode == 2) begin
          req = 1'b1; wr = nx_wr; glitc = nx_glitc; addr = nx_addr; wdata = nx_wdata;
        end
      end
    end

    advance({tag, "/idle"});
    cur_busy = 1'b0;
    check_all({tag, "/idle"});
    $display("txn %s wr=%0d glitc=%0d addr=%h wdata=%h rdata4=%h rdata2=%h",
             tag, w, g, a, d, rdata4, rdata2);
  endtask

  logic        r_w;
  logic [1:0]  r_g, r_s2;
  logic [3:0]  r_s4;
  logic [7:0]  r_a;
  logic [31:0] r_d, r_sl, r_e4, r_e2;
  bit          cee0;

  initial begin
    vecs[0] = '{1'b1, 2'd1, 8'h12, 32'hA1B2C3D4, 32'h0,        4'b1101, 2'b01, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 2'd2, 8'h05, 32'h0,        32'h12345678, 4'b1011, 2'b11, 32'h12345678, 32'hFFFFFFFF};
    vecs[2] = '{1'b0, 2'd3, 8'h3C, 32'h0,        32'hDEADBEEF, 4'b0111, 2'b11, 32'hDEADBEEF, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 2'd0, 8'hFF, 32'h00000000, 32'h0,        4'b1110, 2'b10, 32'hDEADBEEF, 32'hFFFFFFFF};
    vecs[4] = '{1'b0, 2'd1, 8'h00, 32'h0,        32'h0055AAFF, 4'b1101, 2'b01, 32'h0055AAFF, 32'h0055AAFF};
    vecs[5] = '{1'b1, 2'd3, 8'h80, 32'hFFFFFFFF, 32'h0,        4'b0111, 2'b11, 32'h0055AAFF, 32'h0055AAFF};

    // Reset state.
    rst = 1'b1;
    repeat (3) step(cee0);
    check_all("reset");
    rst = 1'b0;
    idle_cycles(4, "post_reset");

    // Table-driven transactions.
    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].glitc, vecs[i].addr, vecs[i].wdata, vecs[i].slave,
              vecs[i].sel4, vecs[i].sel2, vecs[i].rd4, vecs[i].rd2, 0, -1,
              $sformatf("vec%0d", i));
    end

    // Back-to-back: second request raised in the ack cycle; GAP plus the
    // IDLE bus cycle separate the last data beat from the next ADDR.
    nx_wr = 1'b0; nx_glitc = 2'd0; nx_addr = 8'h77; nx_wdata = 32'h0;
    run_txn(1'b1, 2'd2, 8'h40, 32'h11223344, 32'h0, 4'b1011, 2'b11,
            rd4_exp, rd2_exp, 2, -1, "b2b_first");
    run_txn(1'b0, 2'd0, 8'h77, 32'h0, 32'h89ABCDEF, 4'b1110, 2'b10,
            32'h89ABCDEF, 32'h89ABCDEF, 0, -1, "b2b_second");

    // Request held high while busy: exactly one transaction.
    run_txn(1'b1, 2'd3, 8'h21, 32'hCAFEF00D, 32'h0, 4'b0111, 2'b11,
            rd4_exp, rd2_exp, 1, -1, "held_req");
    idle_cycles(6, "held_req/after");

    // Reset during WD2, then a normal read.
    run_txn(1'b1, 2'd1, 8'h33, 32'h01020304, 32'h0, 4'b1101, 2'b01,
            rd4_exp, rd2_exp, 0, 3, "rst_wd2");
    run_txn(1'b0, 2'd1, 8'h44, 32'h0, 32'h0F1E2D3C, 4'b1101, 2'b01,
            32'h0F1E2D3C, 32'h0F1E2D3C, 0, -1, "after_rst");

    // Randomized transactions against the transaction-level model.
    for (int i = 0; i < 16; i++) begin
      r_w  = 1'($urandom_range(0, 1));
      r_g  = 2'($urandom_range(0, 3));
      r_a  = 8'($urandom);
      r_d  = $urandom;
      r_sl = $urandom;
      r_s4 = ~(4'b0001 << r_g);
      r_s2 = (r_g < 2'd2) ? ~(2'b01 << r_g) : 2'b11;
      r_e4 = r_w ? rd4_exp : r_sl;
      r_e2 = r_w ? rd2_exp : ((r_g < 2'd2) ? r_sl : 32'hFFFFFFFF);
      run_txn(r_w, r_g, r_a, r_d, r_sl, r_s4, r_s2, r_e4, r_e2,
              int'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", i));
    end

    idle_cycles(4, "final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
